// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/debug controller: state encodings,
// counter widths and the saturating increment used by the performance counters.
package pipe_ctrl_pkg;

    localparam int STEP_CNT_W = 8;
    localparam int PERF_W     = 32;
    localparam int REG_W      = 5;

    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        STEP = 2'b10,
        BAD  = 2'b11
    } state_e;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] val);
        logic [PERF_W-1:0] res;
        if (val == PERF_MAX) begin
            res = val;
        end else begin
            res = val + PERF_ONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds an
// ID-stage source. Register 0 is hardwired and never creates a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             load_use
);

    assign load_use = mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and debug-halt controller (RUN/HALT/STEP).
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ID_EX_MemRead,
    input  logic [REG_W-1:0]      ID_EX_RegisterRt,
    input  logic [REG_W-1:0]      IF_ID_RegisterRs,
    input  logic [REG_W-1:0]      IF_ID_RegisterRt,
    input  logic                  EX_MEM_Branch_taken,
    input  logic                  EX_MEM_Jump,
    input  logic                  halt_req,
    input  logic                  step_req,
    input  logic [STEP_CNT_W-1:0] step_cnt,
    output logic                  PC_write,
    output logic                  IF_ID_write,
    output logic                  IF_Flush,
    output logic                  ID_Hazard_lwstall,
    output logic                  ID_Hazard_Branch,
    output logic                  EX_MEM_Flush,
    output logic [1:0]            state,
    output logic                  halted,
    output logic [PERF_W-1:0]     stall_count,
    output logic [PERF_W-1:0]     flush_count
);

    state_e                state_r;
    state_e                next_state_s;
    logic [STEP_CNT_W-1:0] step_cnt_r;
    logic [STEP_CNT_W-1:0] step_cnt_nxt_s;
    logic                  load_use_s;
    logic                  flush_req_s;
    logic                  active_s;

    hazard_detect u_hazard_detect (
        .mem_read (ID_EX_MemRead),
        .ex_rt    (ID_EX_RegisterRt),
        .id_rs    (IF_ID_RegisterRs),
        .id_rt    (IF_ID_RegisterRt),
        .load_use (load_use_s)
    );

    assign flush_req_s = EX_MEM_Branch_taken || EX_MEM_Jump;
    assign active_s    = (state_r == RUN) || (state_r == STEP);
    assign state       = state_r;
    assign halted      = (state_r == HALT) && !rst;

    // State and step-burst counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RUN;
            step_cnt_r <= 8'd0;
        end else begin
            state_r    <= next_state_s;
            step_cnt_r <= step_cnt_nxt_s;
        end
    end

    // Next state; the counter holds the remaining cycles of the current burst
    always_comb begin
        next_state_s   = state_r;
        step_cnt_nxt_s = step_cnt_r;
        case (state_r)
            RUN: begin
                if (halt_req) begin
                    next_state_s = HALT;
                end else begin
                    next_state_s = RUN;
                end
            end
            HALT: begin
                if (step_req && (step_cnt != 8'd0)) begin
                    next_state_s   = STEP;
                    step_cnt_nxt_s = step_cnt;
                end else if (!halt_req && !step_req) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = HALT;
                end
            end
            STEP: begin
                if (halt_req || (step_cnt_r <= 8'd1)) begin
                    next_state_s   = HALT;
                    step_cnt_nxt_s = 8'd0;
                end else begin
                    next_state_s   = STEP;
                    step_cnt_nxt_s = step_cnt_r - 8'd1;
                end
            end
            default: begin
                next_state_s   = RUN;
                step_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // Pipeline control; a flush in MEM outranks a load-use stall
    always_comb begin
        PC_write          = 1'b0;
        IF_ID_write       = 1'b0;
        IF_Flush          = 1'b0;
        ID_Hazard_lwstall = 1'b0;
        ID_Hazard_Branch  = 1'b0;
        EX_MEM_Flush      = 1'b0;
        if (rst) begin
            PC_write = 1'b0;
        end else begin
            case (state_r)
                RUN, STEP: begin
                    if (flush_req_s) begin
                        PC_write         = 1'b1;
                        IF_ID_write      = 1'b1;
                        IF_Flush         = 1'b1;
                        ID_Hazard_Branch = 1'b1;
                        EX_MEM_Flush     = 1'b1;
                    end else if (load_use_s) begin
                        ID_Hazard_lwstall = 1'b1;
                    end else begin
                        PC_write    = 1'b1;
                        IF_ID_write = 1'b1;
                    end
                end
                HALT: begin
                    if (flush_req_s) begin
                        IF_ID_write      = 1'b1;
                        IF_Flush         = 1'b1;
                        ID_Hazard_Branch = 1'b1;
                        EX_MEM_Flush     = 1'b1;
                    end else begin
                        ID_Hazard_lwstall = 1'b1;
                    end
                end
                default: begin
                    PC_write = 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_count_r;
    logic [PERF_W-1:0] flush_count_r;
    logic              stall_ev_s;
    logic              flush_ev_s;

    assign stall_ev_s  = active_s && load_use_s && !flush_req_s;
    assign flush_ev_s  = active_s && flush_req_s;
    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;

    // Saturating event counters; HALT cycles are excluded via active_s
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= 32'd0;
            flush_count_r <= 32'd0;
        end else begin
            if (stall_ev_s) begin
                stall_count_r <= sat_inc(stall_count_r);
            end else begin
                stall_count_r <= stall_count_r;
            end
            if (flush_ev_s) begin
                flush_count_r <= sat_inc(flush_count_r);
            end else begin
                flush_count_r <= flush_count_r;
            end
        end
    end
`else
    logic unused_perf_s;
    assign unused_perf_s = active_s;
    assign stall_count   = 32'd0;
    assign flush_count   = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: hazards, flush priority,
// halt/step bursts, abort, reset and (with PIPE_CTRL_PERF_EN) counter saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_RegisterRt;
    logic [4:0]  IF_ID_RegisterRs;
    logic [4:0]  IF_ID_RegisterRt;
    logic        EX_MEM_Branch_taken;
    logic        EX_MEM_Jump;
    logic        halt_req;
    logic        step_req;
    logic [7:0]  step_cnt;
    logic        PC_write;
    logic        IF_ID_write;
    logic        IF_Flush;
    logic        ID_Hazard_lwstall;
    logic        ID_Hazard_Branch;
    logic        EX_MEM_Flush;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    logic [5:0]  ctl;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] exp_stall = 32'd0;
    logic [31:0] exp_flush = 32'd0;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    // {PC_write, IF_ID_write, IF_Flush, lwstall, ID_Hazard_Branch, EX_MEM_Flush}
    assign ctl = {PC_write, IF_ID_write, IF_Flush, ID_Hazard_lwstall, ID_Hazard_Branch, EX_MEM_Flush};

    pipe_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .ID_EX_MemRead       (ID_EX_MemRead),
        .ID_EX_RegisterRt    (ID_EX_RegisterRt),
        .IF_ID_RegisterRs    (IF_ID_RegisterRs),
        .IF_ID_RegisterRt    (IF_ID_RegisterRt),
        .EX_MEM_Branch_taken (EX_MEM_Branch_taken),
        .EX_MEM_Jump         (EX_MEM_Jump),
        .halt_req            (halt_req),
        .step_req            (step_req),
        .step_cnt            (step_cnt),
        .PC_write            (PC_write),
        .IF_ID_write         (IF_ID_write),
        .IF_Flush            (IF_Flush),
        .ID_Hazard_lwstall   (ID_Hazard_lwstall),
        .ID_Hazard_Branch    (ID_Hazard_Branch),
        .EX_MEM_Flush        (EX_MEM_Flush),
        .state               (state),
        .halted              (halted),
        .stall_count         (stall_count),
        .flush_count         (flush_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        ID_EX_MemRead       = 1'b0;
        ID_EX_RegisterRt    = 5'd0;
        IF_ID_RegisterRs    = 5'd0;
        IF_ID_RegisterRt    = 5'd0;
        EX_MEM_Branch_taken = 1'b0;
        EX_MEM_Jump         = 1'b0;
        halt_req            = 1'b0;
        step_req            = 1'b0;
        step_cnt            = 8'd0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_in();
        @(negedge clk);
        n_chk++;
        if (ctl !== 6'b000000 || halted !== 1'b0) begin
            $display("FAIL reset_outputs: ctl=%b halted=%b, expected ctl=000000 halted=0", ctl, halted);
            n_fail++;
        end
        tick();
        @(negedge clk);
        n_chk++;
        if (state !== 2'b00 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
            $display("FAIL reset_state: state=%b stall=%0h flush=%0h, expected 00/0/0", state, stall_count, flush_count);
            n_fail++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_normal;
        clear_in();
        @(negedge clk);
        n_chk++;
        if (ctl !== 6'b110000 || state !== 2'b00 || halted !== 1'b0) begin
            $display("FAIL normal_run: ctl=%b state=%b halted=%b, expected 110000/00/0", ctl, state, halted);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_load_use;
        // Rs match
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd5; IF_ID_RegisterRs = 5'd5; IF_ID_RegisterRt = 5'd0;
        @(negedge clk);
        n_chk++;
        if (ctl !== 6'b000100) begin
            $display("FAIL lu_rs_ctl: ctl=%b, expected 000100", ctl);
            n_fail++;
        end
        tick();
        exp_stall = exp_stall + 32'd1;
        clear_in();
        @(negedge clk);
        n_chk++;
        if (ctl !== 6'b110000 || stall_count !== (PERF ? exp_stall : 32'd0)) begin
            $display("FAIL lu_rs_after: ctl=%b stall=%0h, expected 110000 stall=%0h", ctl, stall_count, PERF ? exp_stall : 32'd0);
            n_fail++;
        end
        // Rt match
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd7; IF_ID_RegisterRs = 5'd1; IF_ID_RegisterRt = 5'd7;
        @(negedge clk);
        n_chk++;
        if (ctl !== 6'b000100) begin
            $display("FAIL lu_rt_ctl: ctl=%b, expected 000100", ctl);
            n_fail++;
        end
        tick();
        exp_stall = exp_stall + 32'd1;
        // Matching registers but no load in EX
        ID_EX_MemRead = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ctl !== 6'b110000 || stall_count !== (PERF ? exp_stall : 32'd0)) begin
            $display("FAIL lu_no_memread: ctl=%b stall=%0h, expected 110000 stall=%0h", ctl, stall_count, PERF ? exp_stall : 32'd0);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_zero_reg;
        clear_in();
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd0; IF_ID_RegisterRs = 5'd0;
        @(negedge clk);
        n_chk++;
        if (ctl !== 6'b110000) begin
            $display("FAIL zero_reg_ctl: ctl=%b, expected 110000", ctl);
            n_fail++;
        end
        tick();
        clear_in();
        @(negedge clk);
        n_chk++;
        if (stall_count !== (PERF ? exp_stall : 32'd0)) begin
            $display("FAIL zero_reg_count: stall=%0h, expected %0h", stall_count, PERF ? exp_stall : 32'd0);
            n_fail++;
        end
    endtask

    task automatic test_branch_lu;
        clear_in();
        EX_MEM_Branch_taken = 1'b1;
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd5; IF_ID_RegisterRs = 5'd5;
        @(negedge clk);
        n_chk++;
        if (ctl !== 6'b111011) begin
            $display("FAIL branch_lu_ctl: ctl=%b, expected 111011", ctl);
            n_fail++;
        end
        tick();
        exp_flush = exp_flush + 32'd1;
        clear_in();
        EX_MEM_Jump = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ctl !== 6'b111011 || flush_count !== (PERF ? 32'd1 : 32'd0) || stall_count !== (PERF ? exp_stall : 32'd0)) begin
            $display("FAIL jump_ctl: ctl=%b flush=%0h stall=%0h, expected 111011 flush=%0h stall=%0h",
                     ctl, flush_count, stall_count, PERF ? 32'd1 : 32'd0, PERF ? exp_stall : 32'd0);
            n_fail++;
        end
        tick();
        exp_flush = exp_flush + 32'd1;
        clear_in();
        @(negedge clk);
        n_chk++;
        if (flush_count !== (PERF ? exp_flush : 32'd0)) begin
            $display("FAIL flush_count: flush=%0h, expected %0h", flush_count, PERF ? exp_flush : 32'd0);
            n_fail++;
        end
    endtask

    task automatic test_step;
        clear_in();
        step_req = 1'b1; step_cnt = 8'd5;
        tick();
        @(negedge clk);
        n_chk++;
        if (state !== 2'b00) begin
            $display("FAIL step_in_run_ignored: state=%b, expected 00", state);
            n_fail++;
        end
        clear_in();
        halt_req = 1'b1;
        tick();
        @(negedge clk);
        n_chk++;
        if (state !== 2'b01 || halted !== 1'b1 || ctl !== 6'b000100) begin
            $display("FAIL halt_entry: state=%b halted=%b ctl=%b, expected 01/1/000100", state, halted, ctl);
            n_fail++;
        end
        // Branch in MEM while halted still flushes, PC stays frozen, not counted
        EX_MEM_Branch_taken = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({PC_write, IF_Flush, ID_Hazard_Branch, EX_MEM_Flush} !== 4'b0111) begin
            $display("FAIL halt_branch: pc/flush bits=%b, expected 0111", {PC_write, IF_Flush, ID_Hazard_Branch, EX_MEM_Flush});
            n_fail++;
        end
        tick();
        EX_MEM_Branch_taken = 1'b0;
        halt_req = 1'b0; step_req = 1'b1; step_cnt = 8'd0;
        tick();
        @(negedge clk);
        n_chk++;
        if (state !== 2'b01) begin
            $display("FAIL step_zero_ignored: state=%b, expected 01", state);
            n_fail++;
        end
        step_cnt = 8'd3;
        tick();
        step_req = 1'b0; step_cnt = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (state !== 2'b10 || PC_write !== 1'b1) begin
                $display("FAIL step_cycle%0d: state=%b PC_write=%b, expected 10/1", i, state, PC_write);
                n_fail++;
            end
            tick();
        end
        @(negedge clk);
        n_chk++;
        if (state !== 2'b01 || halted !== 1'b1) begin
            $display("FAIL step_back_to_halt: state=%b halted=%b, expected 01/1", state, halted);
            n_fail++;
        end
        tick();
        @(negedge clk);
        n_chk++;
        if (state !== 2'b00 || stall_count !== (PERF ? exp_stall : 32'd0) || flush_count !== (PERF ? exp_flush : 32'd0)) begin
            $display("FAIL halt_release: state=%b stall=%0h flush=%0h, expected 00 stall=%0h flush=%0h",
                     state, stall_count, flush_count, PERF ? exp_stall : 32'd0, PERF ? exp_flush : 32'd0);
            n_fail++;
        end
    endtask

    task automatic test_abort_reset;
        clear_in();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; step_req = 1'b1; step_cnt = 8'd10;
        tick();
        step_req = 1'b0; step_cnt = 8'd0;
        @(negedge clk);
        n_chk++;
        if (state !== 2'b10) begin
            $display("FAIL abort_step1: state=%b, expected 10", state);
            n_fail++;
        end
        tick();
        halt_req = 1'b1;
        @(negedge clk);
        n_chk++;
        if (state !== 2'b10) begin
            $display("FAIL abort_step2: state=%b, expected 10", state);
            n_fail++;
        end
        tick();
        @(negedge clk);
        n_chk++;
        if (state !== 2'b01 || dut.step_cnt_r !== 8'd0) begin
            $display("FAIL abort_halt: state=%b cnt=%0d, expected 01/0", state, dut.step_cnt_r);
            n_fail++;
        end
        halt_req = 1'b0; step_req = 1'b1; step_cnt = 8'd10;
        tick();
        step_req = 1'b0; step_cnt = 8'd0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (state !== 2'b10 || ctl !== 6'b000000 || halted !== 1'b0) begin
            $display("FAIL rst_in_step_outputs: state=%b ctl=%b halted=%b, expected 10/000000/0", state, ctl, halted);
            n_fail++;
        end
        tick();
        @(negedge clk);
        n_chk++;
        if (state !== 2'b00 || dut.step_cnt_r !== 8'd0 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
            $display("FAIL rst_in_step_state: state=%b cnt=%0d stall=%0h flush=%0h, expected 00/0/0/0",
                     state, dut.step_cnt_r, stall_count, flush_count);
            n_fail++;
        end
        rst = 1'b0;
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        tick();
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_saturation;
        clear_in();
        force dut.stall_count_r = 32'hFFFFFFFF;
        #1;
        release dut.stall_count_r;
        ID_EX_MemRead = 1'b1; ID_EX_RegisterRt = 5'd9; IF_ID_RegisterRs = 5'd9;
        @(negedge clk);
        n_chk++;
        if (ID_Hazard_lwstall !== 1'b1 || stall_count !== 32'hFFFFFFFF) begin
            $display("FAIL sat_pre: lwstall=%b stall=%0h, expected 1/ffffffff", ID_Hazard_lwstall, stall_count);
            n_fail++;
        end
        tick();
        clear_in();
        @(negedge clk);
        n_chk++;
        if (stall_count !== 32'hFFFFFFFF) begin
            $display("FAIL sat_hold: stall=%0h, expected ffffffff", stall_count);
            n_fail++;
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_in();
        test_reset();
        test_normal();
        test_load_use();
        test_zero_reg();
        test_branch_lu();
        test_step();
        test_abort_reset();
`ifdef PIPE_CTRL_PERF_EN
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have inputs: ID_EX_MemRead  1  load in EX; ID_EX_RegisterRt  5  load destination; IF_ID_RegisterRs  5; IF_ID_RegisterRt  5  ID-stage sources.
REQ-003 SHALL have inputs: EX_MEM_Branch_taken  1  branch resolved taken in MEM; EX_MEM_Jump  1  jump in MEM.
REQ-004 SHALL have inputs: halt_req  1  debug halt; step_req  1  start step burst, one-cycle pulse; step_cnt  8  cycles per burst.
REQ-005 SHALL have outputs: PC_write  1; IF_ID_write  1; IF_Flush  1  clear IF/ID; ID_Hazard_lwstall  1; ID_Hazard_Branch  1  clear ID/EX controls; EX_MEM_Flush  1  clear EX/MEM controls.
REQ-006 SHALL have outputs: state  2  FSM state; halted  1  state==HALT; stall_count  32; flush_count  32.

Function
REQ-007 SHALL implement states RUN=2'b00, HALT=2'b01, STEP=2'b10; 2'b11 unreachable, recovers to RUN next cycle.
REQ-008 SHALL detect load-use as ID_EX_MemRead && ID_EX_RegisterRt!=0 && (ID_EX_RegisterRt==IF_ID_RegisterRs || ID_EX_RegisterRt==IF_ID_RegisterRt), combinationally, same cycle.
REQ-009 SHALL, on load-use in RUN/STEP: ID_Hazard_lwstall=1, PC_write=0, IF_ID_write=0, for exactly the cycle of detection.
REQ-010 SHALL, on EX_MEM_Branch_taken or EX_MEM_Jump in RUN/STEP: IF_Flush=1, ID_Hazard_Branch=1, EX_MEM_Flush=1, PC_write=1, IF_ID_write=1, same cycle.
REQ-011 SHALL give branch/jump flush priority over load-use; ID_Hazard_lwstall=0 when both.
REQ-012 SHALL otherwise drive PC_write=1, IF_ID_write=1, all flush/hazard outputs 0 in RUN/STEP.
REQ-013 SHALL transition RUN->HALT when halt_req=1; HALT->STEP on step_req=1 with step_cnt!=0; HALT->RUN when halt_req=0 and step_req=0.
REQ-014 SHALL load an 8-bit down-counter with step_cnt on HALT->STEP, decrement each STEP cycle, go STEP->HALT in the cycle the counter reaches 1.
REQ-015 SHALL ignore step_req with step_cnt=0, and step_req outside HALT.
REQ-016 SHALL in HALT drive PC_write=0, IF_ID_write=0, ID_Hazard_lwstall=1 (bubbles drain the pipe); branch/jump in MEM during HALT still flushes per REQ-010, except PC_write stays 0.
REQ-017 SHALL let halt_req=1 during STEP abort the burst: STEP->HALT next cycle, counter cleared.

Reset
REQ-018 SHALL on rst: state=RUN, step counter=0, stall_count=0, flush_count=0; rst overrides all other inputs.
REQ-019 SHALL during reset cycle drive PC_write=0, IF_ID_write=0, all flush/hazard outputs 0, halted=0.

Configuration
REQ-020 SHALL with PIPE_CTRL_PERF_EN defined increment stall_count each load-use stall cycle and flush_count each branch/jump flush cycle, both saturating at 32'hFFFFFFFF, HALT cycles not counted.
REQ-021 SHALL without PIPE_CTRL_PERF_EN tie stall_count and flush_count to 0 with no counter flops; ports remain.

Structure
REQ-022 SHALL place state encodings, STEP_CNT_W=8 and PERF_W=32 in shared package pipe_ctrl_pkg.
REQ-023 SHALL put the load-use comparison in sub-module hazard_detect (combinational); FSM, step counter and perf counters stay in pipe_ctrl.

Verification
REQ-024 Load-use: MemRead=1, EX Rt=5, ID Rs=5 -> lwstall=1, PC_write=0, IF_ID_write=0 one cycle; stall_count 0->1.
REQ-025 Zero-register: MemRead=1, EX Rt=0, ID Rs=0 -> no stall, PC_write=1.
REQ-026 Branch+load-use same cycle: Branch_taken=1 with REQ-024 operands -> IF_Flush=ID_Hazard_Branch=EX_MEM_Flush=1, lwstall=0; flush_count 0->1.
REQ-027 Step: halt_req=1 then 0, step_req pulse, step_cnt=3 -> HALT, STEP for exactly 3 cycles with PC_write=1, back to HALT.
REQ-028 Abort/reset: halt_req=1 in 2nd cycle of step_cnt=10 -> HALT next cycle; rst in STEP -> RUN, counters 0 next cycle.
REQ-029 Saturation (PIPE_CTRL_PERF_EN): stall_count forced to 32'hFFFFFFFF, another stall -> stays 32'hFFFFFFFF.
